// File: rtl/encoder_mux_tdm_if.sv
// ---------------------------------------------------------------------------
// encoder_mux_tdm_if
// Bundles the control, encoder-side and output-side signals of
// encoder_mux_tdm. The clock and the asynchronous reset stay outside.
//   resync      : synchronous phase restart
//   enc_mask    : per-encoder slot enable
//   enc_adr_in  : cluster addresses, encoder e / cluster k at (e*NUM_CLUSTERS+k)*ADR_W
//   enc_cnt_in  : cluster counts, same packing with CNT_W per cluster
//   latch_out   : one-hot latch strobes to the encoders
//   adr_out     : selected addresses
//   cnt_out     : selected counts
//   enc_out     : encoder index of the slot now on the output
//   vld_out     : first cycle of a new slot
//   nclust_out  : number of addresses on adr_out that are not the empty marker
// master = the side that drives the encoder data and control.
// slave  = the multiplexer.
// ---------------------------------------------------------------------------
interface encoder_mux_tdm_if #(
    parameter int NUM_ENC      = 2,
    parameter int NUM_CLUSTERS = 8,
    parameter int ADR_W        = 11,
    parameter int CNT_W        = 3
);
    localparam int ENC_W = (NUM_ENC > 1) ? $clog2(NUM_ENC) : 1;
    localparam int NC_W  = $clog2(NUM_CLUSTERS + 1);

    logic                                    resync;
    logic [NUM_ENC-1:0]                      enc_mask;
    logic [NUM_ENC*NUM_CLUSTERS*ADR_W-1:0]   enc_adr_in;
    logic [NUM_ENC*NUM_CLUSTERS*CNT_W-1:0]   enc_cnt_in;
    logic [NUM_ENC-1:0]                      latch_out;
    logic [NUM_CLUSTERS*ADR_W-1:0]           adr_out;
    logic [NUM_CLUSTERS*CNT_W-1:0]           cnt_out;
    logic [ENC_W-1:0]                        enc_out;
    logic                                    vld_out;
    logic [NC_W-1:0]                         nclust_out;

    modport master (
        output resync, enc_mask, enc_adr_in, enc_cnt_in,
        input  latch_out, adr_out, cnt_out, enc_out, vld_out, nclust_out
    );

    modport slave (
        input  resync, enc_mask, enc_adr_in, enc_cnt_in,
        output latch_out, adr_out, cnt_out, enc_out, vld_out, nclust_out
    );
endinterface

// File: rtl/encoder_mux_tdm.sv
// ---------------------------------------------------------------------------
// encoder_mux_tdm
// Time-division multiplexer for NUM_ENC priority encoders on clock4x.
// A free-running phase counter (0..PERIOD-1) produces one latch strobe per
// encoder per round, SLOT = PERIOD/NUM_ENC cycles apart. The phase is carried
// through a SEL_DELAY+1 stage select pipeline together with a "live" bit. The
// delayed phase selects which encoder's cluster bank is loaded into the
// registered output bus.
// Ports:
//   clock4x        : sole clock
//   global_reset_n : asynchronous active-low reset
//   bus            : encoder_mux_tdm_if.slave (control, encoder data, outputs)
// Total latency from a phase value to the output is SEL_DELAY+2 edges.
// ---------------------------------------------------------------------------
module encoder_mux_tdm #(
    parameter int              NUM_ENC      = 2,
    parameter int              NUM_CLUSTERS = 8,
    parameter int              ADR_W        = 11,
    parameter int              CNT_W        = 3,
    parameter int              PERIOD       = 8,
    parameter int              SEL_DELAY    = 0,
    parameter logic [ADR_W-1:0] INVALID_ADR = {ADR_W{1'b1}}
) (
    input  logic            clock4x,
    input  logic            global_reset_n,
    encoder_mux_tdm_if.slave bus
);
    localparam int SLOT     = PERIOD / NUM_ENC;
    localparam int PH_W     = $clog2(PERIOD);
    localparam int SLOT_LOG = $clog2(SLOT);
    localparam int ENC_W    = (NUM_ENC > 1) ? $clog2(NUM_ENC) : 1;
    localparam int NC_W     = $clog2(NUM_CLUSTERS + 1);
    localparam int DEPTH    = SEL_DELAY + 1;

    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(PERIOD - 1);
    localparam logic [PH_W-1:0] SLOT_MASK = PH_W'(SLOT - 1);

    // Number of cluster addresses that are not the empty marker
    function automatic logic [NC_W-1:0] count_valid(input logic [NUM_CLUSTERS*ADR_W-1:0] adr);
        logic [NC_W-1:0] n;
        n = '0;
        for (int k = 0; k < NUM_CLUSTERS; k++) begin
            if (adr[k*ADR_W +: ADR_W] != INVALID_ADR) begin
                n = n + NC_W'(1);
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    logic [PH_W-1:0]              phase_q, phase_d;
    logic [NUM_ENC-1:0]           latch_q, latch_d;
    logic [PH_W-1:0]              ph_chain_q [DEPTH];
    logic [DEPTH-1:0]             live_chain_q;
    logic [PH_W-1:0]              ph_tail_s;
    logic                         live_tail_s;
    logic [ENC_W-1:0]             sel_s;
    logic [NUM_CLUSTERS*ADR_W-1:0] adr_q, adr_d;
    logic [NUM_CLUSTERS*CNT_W-1:0] cnt_q, cnt_d;
    logic [ENC_W-1:0]             enc_q, enc_d;
    logic                         vld_q, vld_d;
    logic [NC_W-1:0]              nclust_q, nclust_d;

    // Phase counter next state and latch strobe decode
    always_comb begin
        phase_d = phase_q;
        latch_d = '0;
        if (bus.resync) begin
            phase_d = '0;
        end else begin
            if (phase_q == PH_LAST) begin
                phase_d = '0;
            end else begin
                phase_d = phase_q + PH_W'(1);
            end
            for (int i = 0; i < NUM_ENC; i++) begin
                latch_d[i] = (phase_q == PH_W'(i * SLOT));
            end
        end
    end

    // Phase counter and latch strobe registers
    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) begin
            phase_q <= '0;
            latch_q <= '0;
        end else begin
            phase_q <= phase_d;
            latch_q <= latch_d;
        end
    end

    // Select pipeline; resync kills every entry in flight so stale phases never raise vld
    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ph_chain_q[i] <= '0;
            end
            live_chain_q <= '0;
        end else begin
            ph_chain_q[0]   <= phase_q;
            live_chain_q[0] <= ~bus.resync;
            for (int i = 1; i < DEPTH; i++) begin
                ph_chain_q[i]   <= ph_chain_q[i-1];
                live_chain_q[i] <= live_chain_q[i-1] & ~bus.resync;
            end
        end
    end

    // Output bank selection; non-live entries look masked but still report their slot index
    always_comb begin
        ph_tail_s   = ph_chain_q[DEPTH-1];
        live_tail_s = live_chain_q[DEPTH-1];
        sel_s       = ENC_W'(ph_tail_s >> SLOT_LOG);
        adr_d       = {NUM_CLUSTERS{INVALID_ADR}};
        cnt_d       = '0;
        nclust_d    = '0;
        enc_d       = sel_s;
        vld_d       = live_tail_s && ((ph_tail_s & SLOT_MASK) == PH_W'(0));
        if (live_tail_s && bus.enc_mask[sel_s]) begin
            for (int k = 0; k < NUM_CLUSTERS; k++) begin
                adr_d[k*ADR_W +: ADR_W] = bus.enc_adr_in[(int'(sel_s) * NUM_CLUSTERS + k) * ADR_W +: ADR_W];
                cnt_d[k*CNT_W +: CNT_W] = bus.enc_cnt_in[(int'(sel_s) * NUM_CLUSTERS + k) * CNT_W +: CNT_W];
            end
            nclust_d = count_valid(adr_d);
        end else begin
            nclust_d = '0;
        end
    end

    // Output registers
    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) begin
            adr_q    <= {NUM_CLUSTERS{INVALID_ADR}};
            cnt_q    <= '0;
            enc_q    <= '0;
            vld_q    <= 1'b0;
            nclust_q <= '0;
        end else begin
            adr_q    <= adr_d;
            cnt_q    <= cnt_d;
            enc_q    <= enc_d;
            vld_q    <= vld_d;
            nclust_q <= nclust_d;
        end
    end

    assign bus.latch_out  = latch_q;
    assign bus.adr_out    = adr_q;
    assign bus.cnt_out    = cnt_q;
    assign bus.enc_out    = enc_q;
    assign bus.vld_out    = vld_q;
    assign bus.nclust_out = nclust_q;
endmodule
